// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between two
// writeback requesters (req0 = ALU, req1 = load unit).
//
// Each requester has a one-entry holding slot with a valid/ready handshake.
// Slots are arbitrated round-robin. The winner drives a registered, active-low
// write strobe with its address and data. Accepted writes to x0 are consumed
// and dropped. Decode can query whether a write to a given index is still
// pending or is being issued this cycle. A wrapping counter tracks issued writes.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   req{0,1}_valid/ready      requester handshake
//   req{0,1}_addr/data        requester destination index and write data
//   rf_write_n/addr/data      registered register-file write port
//   rf_grant                  requester that owns the current strobe
//   q_addr, q_hit             hazard lookup (q_hit is combinational)
//   wr_count                  issued-write counter, wraps
module rf_write_arbiter #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_INIT = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_write_n,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_grant,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic [CNT_W-1:0]  wr_count
);

  // Holding slots
  logic              pend0_q, pend0_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic              pend1_q, pend1_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [DATA_W-1:0] data1_q, data1_d;

  // Round-robin pointer: requester that wins the next tie
  logic ptr_q, ptr_d;

  // Registered write port
  logic              wn_q, wn_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wgrant_q, wgrant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic gnt0, gnt1, acc0, acc1;

  always_comb begin
    gnt0 = pend0_q && (!pend1_q || !ptr_q);
    gnt1 = pend1_q && (!pend0_q || ptr_q);
  end

  // A slot may refill on the same edge it issues. Ready is forced low in reset.
  assign req0_ready = rst && (!pend0_q || gnt0);
  assign req1_ready = rst && (!pend1_q || gnt1);
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  always_comb begin
    pend0_d = pend0_q;
    addr0_d = addr0_q;
    data0_d = data0_q;
    if (gnt0) pend0_d = 1'b0;
    if (acc0) begin
      // x0 writes are consumed but never become pending
      pend0_d = (req0_addr != '0);
      addr0_d = req0_addr;
      data0_d = req0_data;
    end
  end

  always_comb begin
    pend1_d = pend1_q;
    addr1_d = addr1_q;
    data1_d = data1_q;
    if (gnt1) pend1_d = 1'b0;
    if (acc1) begin
      pend1_d = (req1_addr != '0);
      addr1_d = req1_addr;
      data1_d = req1_data;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    wn_d     = 1'b1;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wgrant_d = wgrant_q;
    cnt_d    = cnt_q;
    if (gnt0) begin
      ptr_d    = 1'b1;
      wn_d     = 1'b0;
      waddr_d  = addr0_q;
      wdata_d  = data0_q;
      wgrant_d = 1'b0;
      cnt_d    = cnt_q + CNT_W'(1);
    end else if (gnt1) begin
      ptr_d    = 1'b0;
      wn_d     = 1'b0;
      waddr_d  = addr1_q;
      wdata_d  = data1_q;
      wgrant_d = 1'b1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend0_q  <= 1'b0;
      addr0_q  <= '0;
      data0_q  <= '0;
      pend1_q  <= 1'b0;
      addr1_q  <= '0;
      data1_q  <= '0;
      ptr_q    <= 1'(PRIO_INIT);
      wn_q     <= 1'b1;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wgrant_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pend0_q  <= pend0_d;
      addr0_q  <= addr0_d;
      data0_q  <= data0_d;
      pend1_q  <= pend1_d;
      addr1_q  <= addr1_d;
      data1_q  <= data1_d;
      ptr_q    <= ptr_d;
      wn_q     <= wn_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wgrant_q <= wgrant_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rf_write_n = wn_q;
  assign rf_addr    = waddr_q;
  assign rf_data    = wdata_q;
  assign rf_grant   = wgrant_q;
  assign wr_count   = cnt_q;

  // Covers both queued writes and the write currently on the port
  assign q_hit = rst && (q_addr != '0) &&
                 ((pend0_q && (addr0_q == q_addr)) ||
                  (pend1_q && (addr1_q == q_addr)) ||
                  (!wn_q && (waddr_q == q_addr)));

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int unsigned CNT_W = 4;  // small so the counter wraps in the random run

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_addr, req1_addr, rf_addr, q_addr;
  logic [31:0] req0_data, req1_data, rf_data;
  logic        rf_write_n, rf_grant, q_hit;
  logic [CNT_W-1:0] wr_count;

  rf_write_arbiter #(
    .ADDR_W(5), .DATA_W(32), .PRIO_INIT(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_write_n(rf_write_n), .rf_addr(rf_addr), .rf_data(rf_data),
    .rf_grant(rf_grant), .q_addr(q_addr), .q_hit(q_hit), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending writes per requester as queues, round-robin owner
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t mq0[$];
  wr_t mq1[$];
  int  m_ptr;
  int  exp_g;
  logic exp_rdy0, exp_rdy1, exp_hit, exp_wn, exp_grant;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [CNT_W-1:0] exp_cnt;
  logic obs_rdy0, obs_rdy1, obs_hit;
  logic [31:0] dut_rf [32];

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_ptr     = 0;
    exp_wn    = 1'b1;
    exp_addr  = '0;
    exp_data  = '0;
    exp_grant = 1'b0;
    exp_cnt   = '0;
  endtask

  task automatic model_comb(input logic [4:0] qa);
    if (mq0.size() > 0 && mq1.size() > 0) exp_g = m_ptr;
    else if (mq0.size() > 0) exp_g = 0;
    else if (mq1.size() > 0) exp_g = 1;
    else exp_g = -1;
    exp_rdy0 = (mq0.size() == 0) || (exp_g == 0);
    exp_rdy1 = (mq1.size() == 0) || (exp_g == 1);
    exp_hit  = 1'b0;
    if (qa != 0) begin
      foreach (mq0[i]) if (mq0[i].a == qa) exp_hit = 1'b1;
      foreach (mq1[i]) if (mq1[i].a == qa) exp_hit = 1'b1;
      if (!exp_wn && exp_addr == qa) exp_hit = 1'b1;
    end
  endtask

  task automatic model_edge(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                            input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    wr_t w;
    bit acc0, acc1;
    acc0 = v0 && exp_rdy0;
    acc1 = v1 && exp_rdy1;
    if (exp_g >= 0) begin
      w = (exp_g == 0) ? mq0.pop_front() : mq1.pop_front();
      exp_wn    = 1'b0;
      exp_addr  = w.a;
      exp_data  = w.d;
      exp_grant = (exp_g == 1);
      exp_cnt   = exp_cnt + 1'b1;
      m_ptr     = 1 - exp_g;
    end else begin
      exp_wn = 1'b1;
    end
    if (acc0 && a0 != 0) mq0.push_back({a0, d0});
    if (acc1 && a1 != 0) mq1.push_back({a1, d1});
  endtask

  // One clock: drive at negedge, sample combinational outputs, step model at the
  // rising edge, leave registered outputs settled for the caller to inspect.
  task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] qa);
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    q_addr = qa;
    #1;
    obs_rdy0 = req0_ready;
    obs_rdy1 = req1_ready;
    obs_hit  = q_hit;
    model_comb(qa);
    @(posedge clk);
    model_edge(v0, a0, d0, v1, a1, d1);
    #1;
    if (!rf_write_n) dut_rf[rf_addr] = rf_data;
  endtask

  task automatic idle(input int n, input logic [4:0] qa);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa);
  endtask

  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    req0_data = 0; req1_data = 0; q_addr = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    checks++;
    if (rf_write_n !== 1'b1 || wr_count !== '0 || rf_addr !== '0 || rf_data !== '0
        || rf_grant !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got wn=%b cnt=%0d addr=%0d data=%0h grant=%b expected 1/0/0/0/0",
               rf_write_n, wr_count, rf_addr, rf_data, rf_grant);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b%b expected 11", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 5'd5, 32'd123, 1'b0, 5'd0, 32'd0, 5'd5);
    checks++;
    if (obs_hit !== 1'b0) begin
      errors++; $display("FAIL single_hit_before: got %b expected 0", obs_hit);
    end
    checks++;
    if (rf_write_n !== 1'b1) begin
      errors++; $display("FAIL single_no_early_pulse: got %b expected 1", rf_write_n);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
    checks++;
    if (obs_hit !== 1'b1) begin
      errors++; $display("FAIL single_hit_pending: got %b expected 1", obs_hit);
    end
    checks++;
    if (rf_write_n !== 1'b0 || rf_addr !== 5'd5 || rf_data !== 32'd123 || rf_grant !== 1'b0
        || wr_count !== 4'd1) begin
      errors++;
      $display("FAIL single_issue: got wn=%b addr=%0d data=%0d grant=%b cnt=%0d expected 0/5/123/0/1",
               rf_write_n, rf_addr, rf_data, rf_grant, wr_count);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
    checks++;
    if (obs_hit !== 1'b1) begin
      errors++; $display("FAIL single_hit_issuing: got %b expected 1", obs_hit);
    end
    checks++;
    if (rf_write_n !== 1'b1 || rf_addr !== 5'd5 || wr_count !== 4'd1) begin
      errors++;
      $display("FAIL single_one_pulse: got wn=%b addr=%0d cnt=%0d expected 1/5/1",
               rf_write_n, rf_addr, wr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] order [8] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    logic [4:0] seen [$];
    int first_c, last_c, i0, i1;
    logic v0, v1;
    test_reset();
    i0 = 0; i1 = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 14; c++) begin
      v0 = (i0 < 4);
      v1 = (i1 < 4);
      cycle(v0, 5'(i0 + 1), 32'(100 + i0), v1, 5'(i1 + 11), 32'(200 + i1), 5'd0);
      if (v0 && exp_rdy0) i0++;
      if (v1 && exp_rdy1) i1++;
      if (!rf_write_n) begin
        seen.push_back(rf_addr);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    checks++;
    if (seen.size() != 8) begin
      errors++; $display("FAIL stream_count: got %0d expected 8", seen.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (seen[k] !== order[k]) begin
          errors++;
          $display("FAIL stream_order[%0d]: got %0d expected %0d", k, seen[k], order[k]);
        end
      end
    end
    checks++;
    if (last_c - first_c != 7) begin
      errors++; $display("FAIL stream_rate: got span %0d expected 7", last_c - first_c);
    end
    checks++;
    if (wr_count !== 4'd8) begin
      errors++; $display("FAIL stream_wr_count: got %0d expected 8", wr_count);
    end
  endtask

  task automatic test_x0();
    logic [CNT_W-1:0] cnt0;
    int pulses;
    idle(2, 5'd0);
    cnt0 = wr_count;
    pulses = 0;
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd546, 5'd0);
    checks++;
    if (obs_rdy1 !== 1'b1) begin
      errors++; $display("FAIL x0_ready: got %b expected 1", obs_rdy1);
    end
    checks++;
    if (obs_hit !== 1'b0) begin
      errors++; $display("FAIL x0_qhit: got %b expected 0", obs_hit);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
      if (!rf_write_n) pulses++;
    end
    checks++;
    if (pulses != 0 || wr_count !== cnt0) begin
      errors++;
      $display("FAIL x0_no_write: got pulses=%0d cnt=%0d expected 0/%0d", pulses, wr_count, cnt0);
    end
  endtask

  task automatic test_same_addr();
    logic [31:0] dseq [$];
    test_reset();
    // One req0 write leaves the pointer at requester 1
    cycle(1'b1, 5'd3, 32'd33, 1'b0, 5'd0, 32'd0, 5'd0);
    idle(2, 5'd0);
    cycle(1'b1, 5'd7, 32'd10, 1'b1, 5'd7, 32'd20, 5'd7);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
      if (!rf_write_n && rf_addr == 5'd7) dseq.push_back(rf_data);
    end
    checks++;
    if (dseq.size() != 2) begin
      errors++; $display("FAIL same_addr_count: got %0d expected 2", dseq.size());
    end else begin
      checks++;
      if (dseq[0] !== 32'd20 || dseq[1] !== 32'd10) begin
        errors++;
        $display("FAIL same_addr_order: got %0d,%0d expected 20,10", dseq[0], dseq[1]);
      end
    end
    checks++;
    if (dut_rf[7] !== 32'd10) begin
      errors++; $display("FAIL same_addr_final: got %0d expected 10", dut_rf[7]);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    test_reset();
    cycle(1'b1, 5'd9, 32'd90, 1'b1, 5'd21, 32'd210, 5'd9);
    // Both slots now pending; pulse reset before the issue edge
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #2 rst = 1'b0;
    model_reset();
    #2;
    checks++;
    if (rf_write_n !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || q_hit !== 1'b0) begin
      errors++;
      $display("FAIL midreset_during: got wn=%b rdy=%b%b hit=%b expected 1/00/0",
               rf_write_n, req0_ready, req1_ready, q_hit);
    end
    #3 rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);
      if (!rf_write_n) pulses++;
    end
    checks++;
    if (pulses != 0 || wr_count !== '0 || obs_hit !== 1'b0) begin
      errors++;
      $display("FAIL midreset_dropped: got pulses=%0d cnt=%0d hit=%b expected 0/0/0",
               pulses, wr_count, obs_hit);
    end
    cycle(1'b1, 5'd2, 32'd22, 1'b1, 5'd3, 32'd33, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    checks++;
    if (rf_write_n !== 1'b0 || rf_grant !== 1'b0 || rf_addr !== 5'd2) begin
      errors++;
      $display("FAIL midreset_prio: got wn=%b grant=%b addr=%0d expected 0/0/2",
               rf_write_n, rf_grant, rf_addr);
    end
    // Strobe is low now; reset must drop it without waiting for a clock
    #1 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rf_write_n !== 1'b1) begin
      errors++; $display("FAIL midreset_strobe: got %b expected 1", rf_write_n);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_random();
    logic v0, v1;
    logic [4:0] a0, a1, qa;
    test_reset();
    for (int c = 0; c < 400; c++) begin
      v0 = ($urandom_range(0, 9) < 7);
      v1 = ($urandom_range(0, 9) < 7);
      a0 = 5'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 7));
      qa = 5'($urandom_range(0, 7));
      cycle(v0, a0, 32'($urandom), v1, a1, 32'($urandom), qa);
      checks++;
      if (obs_rdy0 !== exp_rdy0 || obs_rdy1 !== exp_rdy1 || obs_hit !== exp_hit) begin
        errors++;
        $display("FAIL rand_comb c=%0d: got rdy=%b%b hit=%b expected rdy=%b%b hit=%b", c,
                 obs_rdy0, obs_rdy1, obs_hit, exp_rdy0, exp_rdy1, exp_hit);
      end
      checks++;
      if (rf_write_n !== exp_wn || rf_addr !== exp_addr || rf_data !== exp_data
          || rf_grant !== exp_grant || wr_count !== exp_cnt) begin
        errors++;
        $display("FAIL rand_port c=%0d: got %b/%0d/%0h/%b/%0d expected %b/%0d/%0h/%b/%0d", c,
                 rf_write_n, rf_addr, rf_data, rf_grant, wr_count,
                 exp_wn, exp_addr, exp_data, exp_grant, exp_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    req0_data = 0; req1_data = 0; q_addr = 0;
    foreach (dut_rf[i]) dut_rf[i] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_x0();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
